// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with period-aligned divisor updates.
module clk_div_prog #(
  parameter int WIDTH     = 16,
  parameter int DIV_RESET = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_pend,
  output logic             div_err,
  output logic [WIDTH-1:0] div_cur,
  output logic             clk_out,
  output logic             tick
);
  if (DIV_RESET < 2 || longint'(DIV_RESET) > (longint'(1) << WIDTH) - 1) begin : g_bad_reset
    $error("clk_div_prog: DIV_RESET out of range");
  end
  logic [WIDTH-1:0] cnt_q, cnt_d, div_cur_q, div_cur_d, pend_val_q, pend_val_d, half;
  logic pend_q, pend_d, clk_out_q, clk_out_d, tick_q, tick_d, err_q, err_d;
  logic wrap, apply, load_ok;
  // A pending divisor applies on a wrap while running, or on any stopped edge;
  // a load captured on that same edge waits for the following boundary.
  always_comb begin
    wrap       = cnt_q == div_cur_q - WIDTH'(1);
    apply      = pend_q && (wrap || !en);
    load_ok    = div_load && div_in >= WIDTH'(2);
    div_cur_d  = apply ? pend_val_q : div_cur_q;
    pend_d     = load_ok || (pend_q && !apply);
    pend_val_d = load_ok ? div_in : pend_val_q;
    cnt_d      = !en ? div_cur_d - WIDTH'(1) : wrap ? '0 : cnt_q + WIDTH'(1);
    half       = div_cur_d >> 1;
    clk_out_d  = en && cnt_d < half;
    tick_d     = en && cnt_d == '0;
    err_d      = div_load && div_in < WIDTH'(2);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= WIDTH'(DIV_RESET - 1);
      div_cur_q  <= WIDTH'(DIV_RESET);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end
  assign div_pend = pend_q;
  assign div_err  = err_q;
  assign div_cur  = div_cur_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed checks of clk_div_prog with a 4-bit divisor.
module tb_clk_div_prog;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b0, div_load = 1'b0;
  logic [3:0] div_in = '0, div_cur;
  logic       div_pend, div_err, clk_out, tick;
  int checks = 0, errors = 0;
  clk_div_prog #(.WIDTH(4), .DIV_RESET(4)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .div_pend(div_pend), .div_err(div_err), .div_cur(div_cur),
    .clk_out(clk_out), .tick(tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Advance cyc edges of an n-cycle period starting at phase ph0, high for hi cycles.
  task automatic run_pat(input string tag, input int n, input int hi, input int ph0, input int cyc);
    int ph = ph0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_clk"}, {31'd0, clk_out}, (ph < hi) ? 1 : 0);
      chk({tag, "_tick"}, {31'd0, tick}, (ph == 0) ? 1 : 0);
      ph = (ph + 1) % n;
    end
  endtask
  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_clk", {31'd0, clk_out}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_err", {31'd0, div_err}, 0);
    chk("rst_pend", {31'd0, div_pend}, 0);
    chk("rst_cur", {28'd0, div_cur}, 4);
    #1 rst = 1'b0;
    en = 1'b1;
    run_pat("def", 4, 2, 0, 8);
    div_load = 1'b1; div_in = 4'd7;
    run_pat("col_wrap", 4, 2, 0, 1);
    div_load = 1'b0;
    chk("col_pend", {31'd0, div_pend}, 1);
    chk("col_cur", {28'd0, div_cur}, 4);
    run_pat("col4", 4, 2, 1, 3);
    chk("col4_pend", {31'd0, div_pend}, 1);
    run_pat("div7", 7, 3, 0, 1);
    chk("div7_cur", {28'd0, div_cur}, 7);
    chk("div7_pend", {31'd0, div_pend}, 0);
    run_pat("div7", 7, 3, 1, 13);
    run_pat("two", 7, 3, 0, 1);
    div_load = 1'b1; div_in = 4'd6;
    run_pat("two6", 7, 3, 1, 1);
    div_in = 4'd9;
    run_pat("two9", 7, 3, 2, 1);
    div_load = 1'b0;
    run_pat("two", 7, 3, 3, 4);
    chk("two_pend", {31'd0, div_pend}, 1);
    run_pat("div9", 9, 4, 0, 1);
    chk("div9_cur", {28'd0, div_cur}, 9);
    run_pat("div9", 9, 4, 1, 10);
    div_load = 1'b1; div_in = 4'd0;
    run_pat("rej0", 9, 4, 2, 1);
    chk("rej0_err", {31'd0, div_err}, 1);
    div_in = 4'd1;
    run_pat("rej1", 9, 4, 3, 1);
    chk("rej1_err", {31'd0, div_err}, 1);
    chk("rej1_pend", {31'd0, div_pend}, 0);
    div_load = 1'b0;
    run_pat("rej", 9, 4, 4, 1);
    chk("rej_err_clr", {31'd0, div_err}, 0);
    chk("rej_cur", {28'd0, div_cur}, 9);
    run_pat("rej", 9, 4, 5, 5);
    div_load = 1'b1; div_in = 4'd5;
    run_pat("ld5", 9, 4, 1, 1);
    div_load = 1'b0;
    chk("ld5_pend", {31'd0, div_pend}, 1);
    run_pat("ld5", 9, 4, 2, 7);
    chk("ld5_pend_hold", {31'd0, div_pend}, 1);
    chk("ld5_cur_hold", {28'd0, div_cur}, 9);
    run_pat("div5", 5, 2, 0, 11);
    chk("div5_cur", {28'd0, div_cur}, 5);
    chk("div5_pend", {31'd0, div_pend}, 0);
    div_load = 1'b1; div_in = 4'd2;
    run_pat("ld2", 5, 2, 1, 1);
    div_load = 1'b0;
    run_pat("ld2", 5, 2, 2, 3);
    run_pat("div2", 2, 1, 0, 7);
    chk("div2_cur", {28'd0, div_cur}, 2);
    en = 1'b0;
    @(posedge clk); #1;
    chk("stop_clk", {31'd0, clk_out}, 0);
    chk("stop_tick", {31'd0, tick}, 0);
    div_load = 1'b1; div_in = 4'd3;
    @(posedge clk); #1;
    div_load = 1'b0;
    chk("stop_pend", {31'd0, div_pend}, 1);
    chk("stop_cur_old", {28'd0, div_cur}, 2);
    @(posedge clk); #1;
    chk("stop_cur_new", {28'd0, div_cur}, 3);
    chk("stop_pend_clr", {31'd0, div_pend}, 0);
    chk("stop_clk2", {31'd0, clk_out}, 0);
    en = 1'b1;
    run_pat("en3", 3, 1, 0, 6);
    div_load = 1'b1; div_in = 4'd10;
    run_pat("prst", 3, 1, 0, 1);
    div_load = 1'b0;
    chk("prst_pend", {31'd0, div_pend}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_clk", {31'd0, clk_out}, 0);
    chk("arst_tick", {31'd0, tick}, 0);
    chk("arst_pend", {31'd0, div_pend}, 0);
    chk("arst_cur", {28'd0, div_cur}, 4);
    #1 rst = 1'b0;
    run_pat("post_rst", 4, 2, 0, 8);
    chk("post_rst_cur", {28'd0, div_cur}, 4);
    div_load = 1'b1; div_in = 4'd15;
    run_pat("ld15", 4, 2, 0, 1);
    div_load = 1'b0;
    run_pat("ld15", 4, 2, 1, 3);
    run_pat("div15", 15, 7, 0, 15);
    chk("div15_cur", {28'd0, div_cur}, 15);
    chk("div15_peak", {28'd0, dut.cnt_q}, 14);
    run_pat("div15", 15, 7, 0, 1);
    chk("div15_wrap", {28'd0, dut.cnt_q}, 0);
    run_pat("div15", 15, 7, 1, 14);
    chk("div15_peak2", {28'd0, dut.cnt_q}, 14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
